// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared encodings for the UART transmit path
package uart_tx_pkg;

   typedef enum logic [1:0] {
      MUX_START = 2'd0,
      MUX_STOP  = 2'd1,
      MUX_DATA  = 2'd2,
      MUX_PAR   = 2'd3
   } mux_sel_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic DEF_START_BIT = 1'b0;
   localparam logic DEF_STOP_BIT  = 1'b1;

   // Width needed to count 0..w inclusive, so the serializer can saturate at w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/uart_tx_datapath_if.sv
// rtl/uart_tx_datapath_if.sv - control FSM to transmit datapath signal bundle
interface uart_tx_datapath_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_valid;
   logic                  busy;
   logic                  SER_ENABLE;
   logic                  PAR_TYP;
   logic [1:0]            mux_sel;
   logic                  SER_DONE;

   modport master (
      output P_DATA, Data_valid, busy, SER_ENABLE, PAR_TYP, mux_sel,
      input  SER_DONE
   );

   modport slave (
      input  P_DATA, Data_valid, busy, SER_ENABLE, PAR_TYP, mux_sel,
      output SER_DONE
   );
endinterface

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - even/odd parity of a payload word (shared with RX check)
module uart_parity_calc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);
   assign par_bit = (^data) ^ par_typ;
endmodule

// File: rtl/uart_tx_datapath.sv
// rtl/uart_tx_datapath.sv - UART TX byte capture, LSB-first serializer, parity and line mux
module uart_tx_datapath
   import uart_tx_pkg::*;
#(
   parameter int   DATA_WIDTH = 8,
   parameter logic START_BIT  = DEF_START_BIT,
   parameter logic STOP_BIT   = DEF_STOP_BIT
) (
   input  logic                CLK,
   input  logic                RST,
   uart_tx_datapath_if.slave   dp,
   output logic                TX_OUT
);
   localparam int              CW        = cnt_width(DATA_WIDTH);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0]   CNT_FULL  = CW'(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CW-1:0]         bit_cnt;
   logic                  armed;
   logic                  par_bit;
   logic                  par_calc;
   logic                  load;
   logic                  ser_data;
   logic                  tx_next;

   uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data    (dp.P_DATA),
      .par_typ (dp.PAR_TYP),
      .par_bit (par_calc)
   );

   // Loads are only accepted while the FSM is idle/stop, so a frame in flight is never disturbed.
   assign load     = dp.Data_valid && !dp.busy && !dp.SER_ENABLE;
   assign ser_data = shift_reg[0];
   assign dp.SER_DONE = dp.SER_ENABLE && armed && (bit_cnt == CNT_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         shift_reg <= '0;
         par_bit   <= 1'b0;
         bit_cnt   <= '0;
         armed     <= 1'b0;
         TX_OUT    <= STOP_BIT;
      end else begin
         TX_OUT <= tx_next;

         if (load) begin
            shift_reg <= dp.P_DATA;
            par_bit   <= par_calc;
         end else if (dp.SER_ENABLE && armed) begin
            shift_reg <= shift_reg >> 1;
         end

         // First enabled cycle is the START bit: arm without consuming a data bit.
         if (dp.SER_ENABLE) begin
            if (!armed) begin
               armed   <= 1'b1;
               bit_cnt <= '0;
            end else if (bit_cnt != CNT_FULL) begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else begin
            armed   <= 1'b0;
            bit_cnt <= '0;
         end
      end
   end

   always_comb begin
      tx_next = STOP_BIT;
      unique case (mux_sel_e'(dp.mux_sel))
         MUX_START: tx_next = START_BIT;
         MUX_STOP:  tx_next = STOP_BIT;
         MUX_DATA:  tx_next = ser_data;
         MUX_PAR:   tx_next = par_bit;
         default:   tx_next = STOP_BIT;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// tb/tb_uart_tx_datapath.sv - directed frames against a bit-level line model of the TX datapath
module tb_uart_tx_datapath;
   import uart_tx_pkg::*;

   localparam int W = 8;

   logic CLK = 1'b0;
   logic RST;
   logic TX_OUT;
   int   n_checks = 0;
   int   n_pass   = 0;

   uart_tx_datapath_if #(.DATA_WIDTH(W)) bus ();

   uart_tx_datapath #(.DATA_WIDTH(W)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .dp     (bus.slave),
      .TX_OUT (TX_OUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model: the loaded byte, how many of its bits have gone out, and how long SER_ENABLE has been high.
   logic [W-1:0] m_byte;
   logic         m_par;
   int           m_sent;
   int           m_run;
   logic         m_tx;
   logic         model_valid = 1'b0;

   always @(posedge CLK) begin
      model_valid <= 1'b1;
      if (RST) begin
         m_byte <= '0;
         m_par  <= 1'b0;
         m_sent <= 0;
         m_run  <= 0;
         m_tx   <= 1'b1;
      end else begin
         case (bus.mux_sel)
            2'd0:    m_tx <= 1'b0;
            2'd1:    m_tx <= 1'b1;
            2'd2:    m_tx <= (m_sent < W) ? m_byte[m_sent] : 1'b0;
            default: m_tx <= m_par;
         endcase
         if (bus.Data_valid && !bus.busy && !bus.SER_ENABLE) begin
            m_byte <= bus.P_DATA;
            m_par  <= (^bus.P_DATA) ^ bus.PAR_TYP;
            m_sent <= 0;
         end else if (bus.SER_ENABLE && m_run >= 1 && m_sent < W) begin
            m_sent <= m_sent + 1;
         end
         m_run <= bus.SER_ENABLE ? m_run + 1 : 0;
      end
   end

   always @(negedge CLK) begin
      if (model_valid) begin
         check("tx_line", {31'd0, TX_OUT}, {31'd0, m_tx});
         check("ser_done", {31'd0, bus.SER_DONE},
               {31'd0, (!RST && bus.SER_ENABLE && m_run == W)});
      end
   end

   task automatic cyc(input logic r, input logic en, input logic [1:0] mux, input logic dv,
                      input logic [7:0] d, input logic bz, input logic pt,
                      output logic tx, output logic done);
      RST            = r;
      bus.SER_ENABLE = en;
      bus.mux_sel    = mux;
      bus.Data_valid = dv;
      bus.P_DATA     = d;
      bus.busy       = bz;
      bus.PAR_TYP    = pt;
      #2;
      done = bus.SER_DONE;
      @(posedge CLK);
      #1;
      tx = TX_OUT;
   endtask

   task automatic load(input logic [7:0] d, input logic pt);
      logic tx, dn;
      cyc(1'b0, 1'b0, MUX_STOP, 1'b1, d, 1'b0, pt, tx, dn);
   endtask

   // START, W x DATA, PARITY, STOP; optionally pokes loads that must be ignored, and loads in STOP.
   task automatic frame(input bit inject, input bit ld_stop, input logic [7:0] ld_data,
                        input logic ld_pt, output logic [7:0] rx, output logic st,
                        output logic pb, output logic sp, output int ndone, output int done_at);
      logic tx, dn;
      ndone   = 0;
      done_at = -1;
      cyc(1'b0, 1'b1, MUX_START, inject, 8'hFF, !inject, 1'b0, st, dn);
      if (dn) ndone++;
      for (int i = 0; i < W; i++) begin
         cyc(1'b0, 1'b1, MUX_DATA, inject && i == 3, 8'h3C, 1'b1, 1'b0, tx, dn);
         rx[i] = tx;
         if (dn) begin ndone++; done_at = i; end
      end
      cyc(1'b0, 1'b0, MUX_PAR, 1'b0, 8'h00, 1'b1, 1'b0, pb, dn);
      if (dn) ndone++;
      cyc(1'b0, 1'b0, MUX_STOP, ld_stop, ld_data, 1'b0, ld_pt, sp, dn);
      if (dn) ndone++;
   endtask

   task automatic check_frame(input string name, input logic [7:0] exp_byte, input logic exp_par,
                              input logic [7:0] rx, input logic st, input logic pb,
                              input logic sp, input int ndone, input int done_at);
      check({name, "_start"}, {31'd0, st}, 32'd0);
      check({name, "_byte"}, {24'd0, rx}, {24'd0, exp_byte});
      check({name, "_parity"}, {31'd0, pb}, {31'd0, exp_par});
      check({name, "_stop"}, {31'd0, sp}, 32'd1);
      check({name, "_done_cnt"}, ndone, 32'd1);
      check({name, "_done_pos"}, done_at, 32'd7);
   endtask

   initial begin
      logic [7:0] rx;
      logic       st, pb, sp, tx, dn;
      int         nd, da;

      // Reset with arbitrary inputs on the bus
      for (int i = 0; i < 2; i++)
         cyc(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), tx, dn);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_done", {31'd0, bus.SER_DONE}, 32'd0);
      cyc(1'b0, 1'b0, MUX_STOP, 1'b0, 8'h00, 1'b0, 1'b0, tx, dn);
      check("idle_tx", {31'd0, tx}, 32'd1);

      load(8'hA5, PAR_EVEN);
      frame(0, 0, 8'h00, 1'b0, rx, st, pb, sp, nd, da);
      check_frame("a5_even", 8'hA5, 1'b0, rx, st, pb, sp, nd, da);

      // Loads attempted during START (SER_ENABLE high) and mid-DATA (busy) must be ignored
      load(8'hA5, PAR_ODD);
      frame(1, 0, 8'h00, 1'b0, rx, st, pb, sp, nd, da);
      check_frame("a5_odd_blocked", 8'hA5, 1'b1, rx, st, pb, sp, nd, da);

      // Back-to-back frames with loads in the STOP cycle
      load(8'h01, PAR_EVEN);
      frame(0, 1, 8'h01, PAR_ODD, rx, st, pb, sp, nd, da);
      check_frame("x01_even", 8'h01, 1'b1, rx, st, pb, sp, nd, da);
      frame(0, 1, 8'h55, PAR_EVEN, rx, st, pb, sp, nd, da);
      check_frame("x01_odd", 8'h01, 1'b0, rx, st, pb, sp, nd, da);
      frame(0, 0, 8'h00, 1'b0, rx, st, pb, sp, nd, da);
      check_frame("x55_b2b", 8'h55, 1'b0, rx, st, pb, sp, nd, da);

      // SER_ENABLE held past the last data bit
      load(8'hC3, PAR_EVEN);
      nd = 0;
      cyc(1'b0, 1'b1, MUX_START, 1'b0, 8'h00, 1'b1, 1'b0, tx, dn);
      for (int i = 0; i < W + 2; i++) begin
         cyc(1'b0, 1'b1, MUX_DATA, 1'b0, 8'h00, 1'b1, 1'b0, tx, dn);
         if (i < W) rx[i] = tx;
         else check("overrun_bit", {31'd0, tx}, 32'd0);
         if (dn) nd++;
      end
      check("overrun_byte", {24'd0, rx}, 32'hC3);
      check("overrun_done_cnt", nd, 32'd1);
      cyc(1'b0, 1'b0, MUX_PAR, 1'b0, 8'h00, 1'b1, 1'b0, tx, dn);
      check("overrun_parity", {31'd0, tx}, 32'd0);
      cyc(1'b0, 1'b0, MUX_STOP, 1'b0, 8'h00, 1'b0, 1'b0, tx, dn);

      // Reset on the 4th DATA cycle, then a frame without reload sends zeros
      load(8'h96, PAR_ODD);
      cyc(1'b0, 1'b1, MUX_START, 1'b0, 8'h00, 1'b1, 1'b0, tx, dn);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b1, MUX_DATA, 1'b0, 8'h00, 1'b1, 1'b0, tx, dn);
      cyc(1'b1, 1'b1, MUX_DATA, 1'b0, 8'h00, 1'b1, 1'b0, tx, dn);
      check("midrst_tx", {31'd0, tx}, 32'd1);
      cyc(1'b0, 1'b0, MUX_STOP, 1'b0, 8'h00, 1'b0, 1'b0, tx, dn);
      check("midrst_idle", {31'd0, tx}, 32'd1);
      frame(0, 0, 8'h00, 1'b0, rx, st, pb, sp, nd, da);
      check_frame("after_rst", 8'h00, 1'b0, rx, st, pb, sp, nd, da);

      @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
